alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a ready/valid request port and a registered result port.
// Single-cycle operations pass through a one-cycle HOLD state that writes the
// result. MUL runs an iterative shift-add over one bit of b per cycle before
// doing the same. A produced result waits in IDLE with out_valid=1 until the
// consumer takes it. A new request can be accepted in that same cycle.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  // Flag bit positions
  localparam int FC = 0;
  localparam int FL = 1;
  localparam int FF = 2;
  localparam int FZ = 3;
  localparam int FN = 4;

  localparam int                CW      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]  C_WIDTH = WIDTH'(WIDTH);
  localparam logic [CW-1:0]     C_LAST  = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

  state_t             r_state;
  logic [7:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_cin;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [4:0]         r_flags;

  logic               w_accept;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_neg;
  logic               w_zchk;
  logic [WIDTH-1:0]   w_res;
  logic [4:0]         w_flags;

  assign in_ready  = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier bit (LSB of the product register) is set.
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                   + (r_prod[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});

  // Result and flags for the captured operation, consumed in HOLD.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_res   = '0;
    w_flags = '0;
    w_sum   = '0;
    w_neg   = '0;
    w_zchk  = 1'b0;
    case (r_op)
      OP_AND: begin w_res = r_a & r_b; w_zchk = 1'b1; end
      OP_OR:  begin w_res = r_a | r_b; w_zchk = 1'b1; end
      OP_XOR: begin w_res = r_a ^ r_b; w_zchk = 1'b1; end
      OP_ADD, OP_ADDC: begin
        w_sum = {1'b0, r_a} + {1'b0, r_b}
              + ((r_op == OP_ADDC) ? {{WIDTH{1'b0}}, r_cin} : {(WIDTH+1){1'b0}});
        w_res       = w_sum[WIDTH-1:0];
        w_flags[FC] = w_sum[WIDTH];
        w_flags[FF] = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
        w_zchk      = 1'b1;
      end
      OP_SUB: begin
        // Two's-complement subtract: carry-out is the inverse of borrow.
        w_sum       = {1'b0, r_a} + {1'b0, ~r_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res       = w_sum[WIDTH-1:0];
        w_flags[FC] = w_sum[WIDTH];
        w_flags[FF] = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
        w_zchk      = 1'b1;
      end
      OP_CMP: begin
        w_flags[FZ] = (r_a == r_b);
        w_flags[FL] = (r_b < r_a);
        w_flags[FN] = ($signed(r_b) < $signed(r_a));
      end
      OP_LSH: begin
        w_res  = (r_b >= C_WIDTH) ? '0 : (r_a << r_b);
        w_zchk = 1'b1;
      end
      OP_ASHU: begin
        if (!r_b[WIDTH-1]) begin
          w_res = (r_b >= C_WIDTH) ? '0 : (r_a << r_b);
        end else begin
          // Negative count: shift right arithmetically by its magnitude.
          w_neg = -r_b;
          w_res = (w_neg >= C_WIDTH) ? {WIDTH{r_a[WIDTH-1]}}
                                     : WIDTH'($signed(r_a) >>> w_neg);
        end
        w_zchk = 1'b1;
      end
      OP_MUL: begin
        w_res       = r_prod[WIDTH-1:0];
        w_flags[FC] = |r_prod[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
    if (w_zchk) w_flags[FZ] = ~|w_res;
  end

  // Control FSM with operand capture, multiplier iteration and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_cin       <= 1'b0;
      r_prod      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order.
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op        <= op;
            r_a         <= a;
            r_b         <= b;
            r_cin       <= cin;
            r_prod      <= {{WIDTH{1'b0}}, b};
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_state     <= (op == OP_MUL) ? S_MUL : S_HOLD;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_result    <= w_res;
          r_flags     <= w_flags;
          r_out_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=16 with hand-computed vectors.
module tb_alu_seq;

  localparam int W = 16;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request, verify latency, busy behaviour, result and flags, then
  // consume the result. Inputs are scrambled after acceptance.
  task automatic run_op(input string tag, input logic [7:0] t_op,
                        input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                        input logic t_cin, input logic [W-1:0] e_res,
                        input logic [4:0] e_flags, input int e_lat);
    int n;
    int busy;
    @(negedge clk);
    op = t_op; a = t_a; b = t_b; cin = t_cin;
    in_valid = 1'b1; out_ready = 1'b0;
    #1 check({tag, ".rdy"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = OP_ADD; a = 16'hA5A5; b = 16'h5A5A; cin = ~t_cin;
    n = 0;
    busy = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) busy++;
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".lat"}, n, e_lat);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".res"}, result, e_res);
    check({tag, ".flg"}, flags, e_flags);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drain"}, out_valid, 0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ov",  out_valid, 0);
    check("rst.res", result, 0);
    check("rst.flg", flags, 0);
    check("rst.rdy", in_ready, 1);
    // Release mid-phase so the next rising edge is the first one after reset.
    #1 rst_n = 1'b1;

    // Flags: {N,Z,F,L,C}
    run_op("add_wrap",  OP_ADD,  16'hFFFF, 16'h0064, 1'b0, 16'h0063, 5'b00001, 1);
    run_op("add_nocin", OP_ADD,  16'h0001, 16'h0001, 1'b1, 16'h0002, 5'b00000, 1);
    run_op("addc_ovf",  OP_ADDC, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 5'b00100, 1);
    run_op("sub_zero",  OP_SUB,  16'h0005, 16'h0005, 1'b0, 16'h0000, 5'b01001, 1);
    run_op("sub_brw",   OP_SUB,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 5'b00000, 1);
    run_op("sub_ovf",   OP_SUB,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 5'b00101, 1);
    run_op("cmp_sgn",   OP_CMP,  16'h000C, 16'hFFF6, 1'b0, 16'h0000, 5'b10000, 1);
    run_op("cmp_eq",    OP_CMP,  16'h0003, 16'h0003, 1'b0, 16'h0000, 5'b01000, 1);
    run_op("cmp_lt",    OP_CMP,  16'h0009, 16'h0002, 1'b0, 16'h0000, 5'b10010, 1);
    run_op("ashu_neg",  OP_ASHU, 16'h8010, 16'hFFFC, 1'b0, 16'hF801, 5'b00000, 1);
    run_op("ashu_pos",  OP_ASHU, 16'h0003, 16'h0002, 1'b0, 16'h000C, 5'b00000, 1);
    run_op("ashu_fill", OP_ASHU, 16'h8000, 16'hFFE0, 1'b0, 16'hFFFF, 5'b00000, 1);
    run_op("ashu_zf",   OP_ASHU, 16'h4000, 16'hFFEF, 1'b0, 16'h0000, 5'b01000, 1);
    run_op("ashu_big",  OP_ASHU, 16'h0001, 16'h0010, 1'b0, 16'h0000, 5'b01000, 1);
    run_op("lsh_16",    OP_LSH,  16'h0001, 16'h0010, 1'b0, 16'h0000, 5'b01000, 1);
    run_op("lsh_4",     OP_LSH,  16'h0003, 16'h0004, 1'b0, 16'h0030, 5'b00000, 1);
    run_op("lsh_15",    OP_LSH,  16'h0003, 16'h000F, 1'b0, 16'h8000, 5'b00000, 1);
    run_op("and",       OP_AND,  16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 5'b00000, 1);
    run_op("or_zero",   OP_OR,   16'h0000, 16'h0000, 1'b0, 16'h0000, 5'b01000, 1);
    run_op("or",        OP_OR,   16'h1200, 16'h0034, 1'b0, 16'h1234, 5'b00000, 1);
    run_op("undef00",   8'h00,   16'h1234, 16'h1111, 1'b1, 16'h0000, 5'b00000, 1);
    run_op("undefFF",   8'hFF,   16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 5'b00000, 1);
    run_op("mul_ovf",   OP_MUL,  16'h0100, 16'h0101, 1'b0, 16'h0100, 5'b00001, 17);
    run_op("mul_small", OP_MUL,  16'h0003, 16'h0005, 1'b0, 16'h000F, 5'b00000, 17);
    run_op("mul_zero",  OP_MUL,  16'h0000, 16'h1234, 1'b0, 16'h0000, 5'b00000, 17);
    run_op("mul_max",   OP_MUL,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 5'b00001, 17);

    // Result held under backpressure, then back-to-back acceptance.
    @(negedge clk);
    op = OP_XOR; a = 16'h0028; b = 16'h0064; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp.ov", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.hold_res", result, 16'h004C);
      check("bp.hold_rdy", in_ready, 0);
      check("bp.hold_ov",  out_valid, 1);
    end
    @(negedge clk);
    op = OP_ADD; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("b2b.rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.ov0", out_valid, 0);
    @(posedge clk); #1;
    check("b2b.ov1", out_valid, 1);
    check("b2b.res", result, 16'h0003);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = OP_MUL; a = 16'h1234; b = 16'h0101; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mrst.ov",  out_valid, 0);
    check("mrst.res", result, 0);
    check("mrst.flg", flags, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("mrst.noout", seen, 0);
    check("mrst.rdy", in_ready, 1);

    run_op("post_rst", OP_XOR, 16'h00FF, 16'h0F0F, 1'b0, 16'h0FF0, 5'b00000, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
